// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: func3 encodings, opcodes,
// FSM state type and the access legality check used at request time.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [2:0] {StIdle, StReq, StWait, StDone, StErr} lsu_state_t;

    // Legal func3 for the access direction and natural alignment of the size.
    function automatic logic access_ok(logic is_load, logic [2:0] f3, logic [1:0] off);
        logic f3_ok;
        logic algn_ok;
        case (f3)
            F3_B, F3_H, F3_W: f3_ok = 1'b1;
            F3_BU, F3_HU:     f3_ok = is_load;
            default:          f3_ok = 1'b0;
        endcase
        case (f3[1:0])
            2'b01:   algn_ok = ~off[0];
            2'b10:   algn_ok = (off == 2'b00);
            default: algn_ok = 1'b1;
        endcase
        return f3_ok & algn_ok;
    endfunction

endpackage

// File: rtl/lsu_controller_if.sv
// Data memory request/grant/response bus between the LSU (master) and the memory (slave).
interface lsu_controller_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [3:0]            mem_be;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu_data_align.sv
// Combinational lane steering: byte enables and replicated store data on the way out,
// byte/halfword selection with sign or zero extension on the way back.
module lsu_data_align
    import lsu_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  func3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        be    = 4'b0000;
        wdata = store_data;
        case (func3[1:0])
            2'b00: begin
                be    = 4'b0001 << offset;
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << {offset[1], 1'b0};
                wdata = {2{store_data[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        if (!is_store) be = 4'b0000;
    end

    always_comb begin
        case (offset)
            2'd0:    rbyte = rdata[7:0];
            2'd1:    rbyte = rdata[15:8];
            2'd2:    rbyte = rdata[23:16];
            default: rbyte = rdata[31:24];
        endcase
        rhalf = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        case (func3)
            F3_B:    load_data = {{24{rbyte[7]}}, rbyte};
            F3_BU:   load_data = {24'd0, rbyte};
            F3_H:    load_data = {{16{rhalf[15]}}, rhalf};
            F3_HU:   load_data = {16'd0, rhalf};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_controller.sv
// Multi-cycle load/store sequencer: holds the core stalled while a single access runs
// through the req/gnt/rvalid memory handshake, with misalignment and timeout aborts.
module lsu_controller
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ld_req,
    input  logic                  st_req,
    input  logic [2:0]            func3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] store_data,
    lsu_controller_if.master      mem,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  stall,
    output logic                  done,
    output logic                  misaligned,
    output logic                  timeout
);
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CntW-1:0] TmoLast = CntW'(TIMEOUT_CYCLES - 1);

    lsu_state_t            state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  err_tmo_q, err_tmo_d;
    logic                  store_q;
    logic [2:0]            func3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] load_q;
    logic                  latch;
    logic                  req_any;
    logic                  req_ok;
    logic                  tmo_hit;
    logic [DATA_WIDTH-1:0] ext_data;

    assign req_any = ld_req | st_req;
    // ld_req wins when both are raised, so legality is judged as a load.
    assign req_ok  = access_ok(ld_req, func3, addr[1:0]);
    assign tmo_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TmoLast);

    lsu_data_align u_align (
        .is_store   (store_q),
        .func3      (func3_q),
        .offset     (addr_q[1:0]),
        .store_data (wdata_q),
        .rdata      (mem.mem_rdata),
        .be         (mem.mem_be),
        .wdata      (mem.mem_wdata),
        .load_data  (ext_data)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_tmo_d = err_tmo_q;
        latch     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_any) begin
                    cnt_d = '0;
                    if (req_ok) begin
                        state_d = StReq;
                        latch   = 1'b1;
                    end else begin
                        state_d   = StErr;
                        err_tmo_d = 1'b0;
                    end
                end
            end
            StReq: begin
                cnt_d = cnt_q + CntW'(1);
                if (mem.mem_gnt) begin
                    state_d = store_q ? StDone : StWait;
                end else if (tmo_hit) begin
                    state_d   = StErr;
                    err_tmo_d = 1'b1;
                end
            end
            StWait: begin
                cnt_d = cnt_q + CntW'(1);
                if (mem.mem_rvalid) begin
                    state_d = StDone;
                end else if (tmo_hit) begin
                    state_d   = StErr;
                    err_tmo_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            err_tmo_q <= 1'b0;
            store_q   <= 1'b0;
            func3_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            load_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_tmo_q <= err_tmo_d;
            if (latch) begin
                store_q <= ~ld_req;
                func3_q <= func3;
                addr_q  <= addr;
                wdata_q <= store_data;
            end
            if (state_q == StWait && mem.mem_rvalid) load_q <= ext_data;
        end
    end

    assign mem.mem_req  = (state_q == StReq);
    assign mem.mem_we   = store_q;
    assign mem.mem_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign load_data    = load_q;
    assign done         = (state_q == StDone);
    assign misaligned   = (state_q == StErr) & ~err_tmo_q;
    assign timeout      = (state_q == StErr) & err_tmo_q;
    assign stall        = rst_n & (((state_q == StIdle) & req_any) |
                                   (state_q == StReq) | (state_q == StWait));

endmodule

// File: tb/tb_lsu_controller.sv
// Self-checking bench for lsu_controller: directed cases plus randomized accesses
// compared against an arithmetic model of lane steering, extension and timing.
module tb_lsu_controller;
    logic        clk;
    logic        rst_n;
    logic        ld_req, st_req, to_ld;
    logic [2:0]  func3;
    logic [31:0] addr, store_data;
    logic [31:0] load_data, to_load_data;
    logic        stall, done, misaligned, timeout;
    logic        to_stall, to_done, to_mis, to_timeout;
    int          total, bad;
    logic [31:0] last_ld;

    lsu_controller_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m ();
    lsu_controller_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mt ();

    lsu_controller #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .rst_n(rst_n), .ld_req(ld_req), .st_req(st_req), .func3(func3),
        .addr(addr), .store_data(store_data), .mem(m), .load_data(load_data),
        .stall(stall), .done(done), .misaligned(misaligned), .timeout(timeout)
    );

    lsu_controller #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut_to (
        .clk(clk), .rst_n(rst_n), .ld_req(to_ld), .st_req(1'b0), .func3(func3),
        .addr(addr), .store_data(store_data), .mem(mt), .load_data(to_load_data),
        .stall(to_stall), .done(to_done), .misaligned(to_mis), .timeout(to_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One access from request to return-to-idle, with gd extra REQ cycles before gnt
    // and rd extra WAIT cycles before rvalid.
    task automatic do_access(input string name, input bit is_ld, input bit both,
                             input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] sd, input logic [31:0] rdw,
                             input int gd, input int rd);
        bit          ld_eff;
        bit          legal;
        int          n;
        logic [3:0]  ebe;
        logic [31:0] ewd, eld, mask;
        ld_eff = is_ld | both;
        n      = 1 << f3[1:0];
        legal  = (f3[1:0] != 2'b11) && (a % n == 0) &&
                 (ld_eff ? (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) : (f3 < 3));
        ebe    = ld_eff ? 4'b0 : 4'(((1 << n) - 1) << (a % 4));
        for (int i = 0; i < 4; i++) ewd[8*i +: 8] = sd[8*(i % n) +: 8];
        mask = (n >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
        eld  = (rdw >> (8 * (a % 4))) & mask;
        if (!f3[2] && n < 4 && eld[8*n-1]) eld = eld | ~mask;

        ld_req = ld_eff; st_req = !is_ld | both; func3 = f3; addr = a; store_data = sd;
        m.mem_rdata = rdw; m.mem_gnt = 1'b0; m.mem_rvalid = 1'b0;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL %s idle_stall got=%b exp=1", name, stall); end
        total++; if (m.mem_req !== 1'b0) begin bad++; $display("FAIL %s idle_req got=%b exp=0", name, m.mem_req); end
        @(posedge clk); #1;
        if (!legal) begin
            total++; if (misaligned !== 1'b1) begin bad++; $display("FAIL %s misaligned got=%b exp=1", name, misaligned); end
            total++; if ({done, timeout, m.mem_req, stall} !== 4'b0) begin bad++;
                $display("FAIL %s err_outs done/tmo/req/stall got=%b exp=0000", name, {done, timeout, m.mem_req, stall}); end
        end else begin
            for (int k = 0; k <= gd; k++) begin
                m.mem_gnt = (k == gd);
                #1;
                total++; if (m.mem_req !== 1'b1 || stall !== 1'b1) begin bad++;
                    $display("FAIL %s req_cycle%0d req/stall got=%b%b exp=11", name, k, m.mem_req, stall); end
                total++; if (m.mem_we !== !ld_eff) begin bad++; $display("FAIL %s we got=%b exp=%b", name, m.mem_we, !ld_eff); end
                total++; if (m.mem_addr !== (a & ~32'd3)) begin bad++;
                    $display("FAIL %s mem_addr got=%h exp=%h", name, m.mem_addr, a & ~32'd3); end
                total++; if (m.mem_be !== ebe) begin bad++; $display("FAIL %s mem_be got=%b exp=%b", name, m.mem_be, ebe); end
                if (!ld_eff) begin
                    total++; if (m.mem_wdata !== ewd) begin bad++;
                        $display("FAIL %s mem_wdata got=%h exp=%h", name, m.mem_wdata, ewd); end
                end
                @(posedge clk); #1;
            end
            m.mem_gnt = 1'b0;
            if (ld_eff) begin
                for (int k = 0; k <= rd; k++) begin
                    m.mem_rvalid = (k == rd);
                    #1;
                    total++; if ({m.mem_req, stall, done} !== 3'b010) begin bad++;
                        $display("FAIL %s wait%0d req/stall/done got=%b exp=010", name, k, {m.mem_req, stall, done}); end
                    @(posedge clk); #1;
                end
                m.mem_rvalid = 1'b0;
                m.mem_rdata  = $urandom;
                last_ld      = eld;
            end
            #1;
            total++; if ({done, stall, misaligned, timeout} !== 4'b1000) begin bad++;
                $display("FAIL %s done_cycle done/stall/mis/tmo got=%b exp=1000", name, {done, stall, misaligned, timeout}); end
            total++; if (load_data !== last_ld) begin bad++;
                $display("FAIL %s load_data got=%h exp=%h", name, load_data, last_ld); end
        end
        ld_req = 1'b0; st_req = 1'b0;
        @(posedge clk); #1;
        total++; if ({done, misaligned, timeout, stall, m.mem_req} !== 5'b0) begin bad++;
            $display("FAIL %s back_idle outs got=%b exp=00000", name, {done, misaligned, timeout, stall, m.mem_req}); end
        total++; if (load_data !== last_ld) begin bad++;
            $display("FAIL %s load_hold got=%h exp=%h", name, load_data, last_ld); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ld_req = 1'b1; st_req = 1'b0; to_ld = 1'b0; func3 = 3'b010;
        addr = 32'h0; store_data = 32'h0; last_ld = 32'h0;
        m.mem_gnt = 1'b0; m.mem_rvalid = 1'b0; m.mem_rdata = 32'h0;
        mt.mem_gnt = 1'b0; mt.mem_rvalid = 1'b0; mt.mem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset stall got=%b exp=0", stall); end
        total++; if ({m.mem_req, m.mem_we, done, misaligned, timeout} !== 5'b0) begin bad++;
            $display("FAIL reset outs got=%b exp=00000", {m.mem_req, m.mem_we, done, misaligned, timeout}); end
        total++; if (load_data !== 32'h0) begin bad++; $display("FAIL reset load_data got=%h exp=0", load_data); end
        ld_req = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        do_access("sb_0x103", 1'b0, 1'b0, 3'b000, 32'h103, 32'h0000_00A5, 32'h0, 0, 0);
        do_access("lb_0x201", 1'b1, 1'b0, 3'b000, 32'h201, 32'h0, 32'h1234_F678, 2, 0);
        total++; if (last_ld !== 32'hFFFF_FFF6) begin bad++; $display("FAIL lb_model got=%h exp=fffffff6", last_ld); end
        do_access("lbu_0x201", 1'b1, 1'b0, 3'b100, 32'h201, 32'h0, 32'h1234_F678, 2, 0);
        total++; if (last_ld !== 32'h0000_00F6) begin bad++; $display("FAIL lbu_model got=%h exp=000000f6", last_ld); end
        do_access("lh_0x202", 1'b1, 1'b0, 3'b001, 32'h202, 32'h0, 32'h8001_0203, 0, 1);
        do_access("sh_0x206", 1'b0, 1'b0, 3'b001, 32'h206, 32'hDEAD_BEEF, 32'h0, 1, 0);
        do_access("lw_0x302_mis", 1'b1, 1'b0, 3'b010, 32'h302, 32'h0, 32'h0, 0, 0);
        do_access("sh_0x101_mis", 1'b0, 1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 0, 0);
        do_access("ld_f3_011", 1'b1, 1'b0, 3'b011, 32'h400, 32'h0, 32'h0, 0, 0);
        do_access("st_f3_100", 1'b0, 1'b0, 3'b100, 32'h400, 32'h0, 32'h0, 0, 0);
        do_access("ld_st_both", 1'b1, 1'b1, 3'b010, 32'h10, 32'h5555_AAAA, 32'hCAFE_F00D, 1, 0);
    endtask

    task automatic test_timeout();
        to_ld = 1'b1; func3 = 3'b010; addr = 32'h80;
        #1;
        total++; if (to_stall !== 1'b1) begin bad++; $display("FAIL tmo idle_stall got=%b exp=1", to_stall); end
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            total++; if ({mt.mem_req, to_timeout} !== 2'b10) begin bad++;
                $display("FAIL tmo req%0d req/tmo got=%b exp=10", k, {mt.mem_req, to_timeout}); end
            @(posedge clk); #1;
        end
        total++; if (to_timeout !== 1'b1) begin bad++; $display("FAIL tmo pulse got=%b exp=1", to_timeout); end
        total++; if ({mt.mem_req, to_done, to_mis, to_stall} !== 4'b0) begin bad++;
            $display("FAIL tmo err_outs got=%b exp=0000", {mt.mem_req, to_done, to_mis, to_stall}); end
        to_ld = 1'b0;
        @(posedge clk); #1;
        total++; if ({to_timeout, mt.mem_req, to_stall} !== 3'b0) begin bad++;
            $display("FAIL tmo idle got=%b exp=000", {to_timeout, mt.mem_req, to_stall}); end
    endtask

    task automatic test_reset_mid();
        ld_req = 1'b1; st_req = 1'b0; func3 = 3'b010; addr = 32'h20; m.mem_gnt = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        m.mem_gnt = 1'b0;
        total++; if ({m.mem_req, stall} !== 2'b01) begin bad++;
            $display("FAIL rst_mid wait req/stall got=%b exp=01", {m.mem_req, stall}); end
        #1 rst_n = 1'b0;
        #1;
        total++; if ({m.mem_req, stall, done} !== 3'b0) begin bad++;
            $display("FAIL rst_mid async req/stall/done got=%b exp=000", {m.mem_req, stall, done}); end
        ld_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; last_ld = 32'h0;
        @(posedge clk); #1;
        do_access("sw_0x40_after_rst", 1'b0, 1'b0, 3'b010, 32'h40, 32'h0BAD_F00D, 32'h0, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            do_access($sformatf("rand%0d", i), bit'($urandom_range(0, 1)), 1'b0,
                      3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                      $urandom_range(0, 3), $urandom_range(0, 2));
        end
    endtask

    initial begin
        total = 0; bad = 0;
        test_reset();
        test_directed();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_controller.md
Name: lsu_controller

Overview:
- Multi-cycle load/store sequencer between the single-cycle core and a data memory with a req/gnt/rvalid handshake.
- Takes the decoder's dmem_read_en/dmem_write_en, func3, the ALU address and rs2 data.
- Drives the memory request with byte enables and lane-replicated store data, and returns the extended load result.
- Stalls the PC until the access completes; flags misaligned/illegal accesses and memory timeouts.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data width; only 32 is supported.
- TIMEOUT_CYCLES, 255, maximum cycles spent in REQ+WAIT before abort; 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- ld_req  input  1  load request (decoder dmem_read_en)
- st_req  input  1  store request (decoder dmem_write_en)
- func3  input  3  instruction[14:12], access size/sign
- addr  input  ADDR_WIDTH  effective byte address (ALU result)
- store_data  input  DATA_WIDTH  rs2 value
- mem_req  output  1  memory request valid
- mem_we  output  1  1 = write
- mem_addr  output  ADDR_WIDTH  word address, bits [1:0] = 0
- mem_wdata  output  DATA_WIDTH  lane-replicated store data
- mem_be  output  4  byte enables
- mem_gnt  input  1  request accepted
- mem_rvalid  input  1  read data valid
- mem_rdata  input  DATA_WIDTH  read word
- load_data  output  DATA_WIDTH  extended load result, valid while done=1
- stall  output  1  hold PC/instruction
- done  output  1  access complete; gates the load write-back
- misaligned  output  1  misaligned/illegal-func3 pulse
- timeout  output  1  memory timeout pulse

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n). Reset forces state IDLE, counter 0, and every registered output to 0. stall is forced to 0 while rst_n = 0. Reset mid-access drops mem_req immediately; the memory must tolerate an abandoned request.
- States: IDLE, REQ, WAIT, DONE, ERR.
- IDLE, any request:
  - ld_req has priority when ld_req and st_req are both high.
  - Legal load func3: 000, 001, 010, 100, 101. Legal store func3: 000, 001, 010.
  - Alignment: halfword requires addr[0] = 0; word requires addr[1:0] = 00.
  - Legal and aligned: latch addr, func3, offset and the write/read type, then go to REQ.
  - Otherwise: go to ERR with no memory request.
- IDLE stall: combinational high whenever ld_req or st_req is high.
- REQ:
  - Outputs: mem_req = 1, mem_we = store, mem_addr = {addr[ADDR_WIDTH-1:2], 2'b00}.
  - mem_be: sb 0001 << addr[1:0]; sh 0011 << {addr[1], 0}; sw 1111. mem_be = 0 for loads.
  - mem_wdata: sb = byte replicated 4x; sh = halfword replicated 2x; sw = as-is.
  - Request fields stay stable until gnt.
  - On mem_gnt: a store goes to DONE, a load goes to WAIT. mem_req is low from the next cycle.
- WAIT: on mem_rvalid, latch the extracted load data and go to DONE. The earliest mem_rvalid is the cycle after gnt; rvalid in any other state is ignored.
- Load extraction by offset:
  - lb: sign-extend the selected byte. lbu: zero-extend the selected byte.
  - lh: sign-extend the selected halfword. lhu: zero-extend the selected halfword.
  - lw: full word.
- DONE: one cycle with done = 1, stall = 0, load_data held; then go to IDLE unconditionally, ignoring requests in that cycle (same instruction).
- ERR: one cycle with stall = 0, done = 0, and misaligned or timeout = 1; then go to IDLE.
- stall = (IDLE & (ld_req | st_req)) | REQ | WAIT.
- Timeout counter: cleared on entry to REQ, increments each REQ/WAIT cycle. When count reaches TIMEOUT_CYCLES, go to ERR with timeout = 1 and deassert mem_req.
- Latency, store with immediate gnt: 3 cycles (IDLE, REQ, DONE).
- Latency, load with gnt in REQ and rvalid on the first WAIT cycle: 4 cycles.
- done, misaligned and timeout are mutually exclusive single-cycle pulses.
- load_data holds its last value outside DONE.

Decomposition:
- Package lsu_pkg:
  - func3 constants F3_B = 000, F3_H = 001, F3_W = 010, F3_BU = 100, F3_HU = 101.
  - State enum lsu_state_t.
  - Opcode constants OP_LOAD = 0000011, OP_STORE = 0100011.
- Sub-module lsu_data_align, purely combinational:
  - Store side: func3 + offset -> mem_be and replicated wdata.
  - Load side: func3 + offset + rdata -> extended load_data.
- lsu_controller keeps the FSM, the timeout counter and the latches.

Test Plan:
- sb: addr = 0x103, store_data = 0x000000A5, gnt on the first REQ cycle -> mem_addr = 0x100, mem_be = 1000, mem_wdata = 0xA5A5A5A5, mem_we = 1; stall high 2 cycles; done pulses in cycle 3.
- lb / lbu: addr = 0x201, rdata = 0x1234F678, gnt after 2 wait cycles, rvalid 1 cycle later -> lb load_data = 0xFFFFFFF6; lbu load_data = 0x000000F6; done asserted exactly 1 cycle.
- Misaligned: lw at addr = 0x302 -> ERR next cycle with misaligned = 1; mem_req never asserted; done = 0.
- Timeout: TIMEOUT_CYCLES = 4, no gnt -> timeout pulse after 4 REQ cycles; mem_req low from the ERR cycle; returns to IDLE.
- Reset mid-access: rst_n low during WAIT -> mem_req = 0, stall = 0, done = 0 asynchronously; after release a fresh sw at 0x40 completes normally with mem_be = 1111.
- Illegal func3 and simultaneous requests: load func3 = 011 -> misaligned pulse; ld_req = st_req = 1 -> read issued (mem_we = 0).
